// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receiver
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    localparam int DIV_MIN = 4;

    // Mode 2'b11 is an alias for no parity.
    function automatic parity_t decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   decode_parity = PAR_EVEN;
            2'b10:   decode_parity = PAR_ODD;
            default: decode_parity = PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - received-word stream from the UART receiver to its consumer
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_BITS-1:0] data;
    logic                 vld;
    logic                 rdy;
    logic                 par_err;
    logic [LEVEL_W-1:0]   level;

    modport master (output data, vld, par_err, level, input rdy);
    modport slave  (input data, vld, par_err, level, output rdy);
endinterface

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through synchronous FIFO
// Simultaneous push and pop is honoured even when full.
module sync_fifo_fwft #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign level_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i & ~empty_o;
        do_push  = push_i & (~full_o | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with runtime parity/stop selection and receive FIFO
// Synchroniser, framing FSM, baud/bit counters, parity and sticky error flags live here.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 uart_rx_i,
    input  logic [DIV_WIDTH-1:0] uart_rx_baud_div_i,
    input  logic [1:0]           uart_rx_parity_i,
    input  logic                 uart_rx_stop2_i,
    input  logic                 uart_rx_err_clr_i,
    output logic                 uart_rx_frame_err_o,
    output logic                 uart_rx_ovr_err_o,
    uart_rx_fifo_if.master       rx_if
);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

    rx_state_t            state_q, state_d;
    logic                 sync1_q, rx_s_q;
    logic                 armed_q, armed_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_acc_q, par_acc_d;
    logic                 par_err_q, par_err_d;
    parity_t              parity_q, parity_d;
    logic                 stop2_q, stop2_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 push_q, push_d;
    logic                 frame_err_q, frame_err_d;
    logic                 ovr_err_q, ovr_err_d;
    logic                 frame_set, ovr_set, stop_bad;
    logic [DIV_WIDTH-1:0] div_eff;

    logic [DATA_BITS:0]   fifo_rdata;
    logic                 fifo_full, fifo_empty, fifo_pop;

    assign div_eff = (uart_rx_baud_div_i < DIV_WIDTH'(DIV_MIN)) ? DIV_WIDTH'(DIV_MIN)
                                                                : uart_rx_baud_div_i;
    assign fifo_pop = ~fifo_empty & rx_if.rdy;

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q | rx_s_q;
        div_d      = div_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_acc_d  = par_acc_q;
        par_err_d  = par_err_q;
        parity_d   = parity_q;
        stop2_d    = stop2_q;
        stop_bad_d = stop_bad_q;
        push_d     = 1'b0;
        frame_set  = 1'b0;
        stop_bad   = stop_bad_q | ~rx_s_q;

        case (state_q)
            ST_IDLE: begin
                // Frame settings are captured here and held until the frame ends.
                if (armed_q && !rx_s_q) begin
                    div_d      = div_eff;
                    parity_d   = decode_parity(uart_rx_parity_i);
                    stop2_d    = uart_rx_stop2_i;
                    baud_cnt_d = (div_eff >> 1) - DIV_ONE;
                    bit_cnt_d  = '0;
                    par_acc_d  = 1'b0;
                    par_err_d  = 1'b0;
                    stop_bad_d = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (baud_cnt_q != '0) begin
                    baud_cnt_d = baud_cnt_q - DIV_ONE;
                end else if (rx_s_q) begin
                    state_d = ST_IDLE;
                end else begin
                    baud_cnt_d = div_q - DIV_ONE;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_cnt_q != '0) begin
                    baud_cnt_d = baud_cnt_q - DIV_ONE;
                end else begin
                    shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    par_acc_d  = par_acc_q ^ rx_s_q;
                    baud_cnt_d = div_q - DIV_ONE;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (parity_q == PAR_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_cnt_q != '0) begin
                    baud_cnt_d = baud_cnt_q - DIV_ONE;
                end else begin
                    par_err_d  = (parity_q == PAR_EVEN) ? (par_acc_q ^ rx_s_q)
                                                        : ~(par_acc_q ^ rx_s_q);
                    baud_cnt_d = div_q - DIV_ONE;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (baud_cnt_q != '0) begin
                    baud_cnt_d = baud_cnt_q - DIV_ONE;
                end else if (stop2_q && bit_cnt_q == '0) begin
                    stop_bad_d = stop_bad;
                    bit_cnt_d  = 3'd1;
                    baud_cnt_d = div_q - DIV_ONE;
                end else begin
                    state_d   = ST_IDLE;
                    frame_set = stop_bad;
                    push_d    = ~stop_bad;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ovr_set     = push_q & fifo_full & ~fifo_pop;
        frame_err_d = (frame_err_q & ~uart_rx_err_clr_i) | frame_set;
        ovr_err_d   = (ovr_err_q & ~uart_rx_err_clr_i) | ovr_set;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b0;
            rx_s_q      <= 1'b0;
            armed_q     <= 1'b0;
            div_q       <= DIV_WIDTH'(DIV_MIN);
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_acc_q   <= 1'b0;
            par_err_q   <= 1'b0;
            parity_q    <= PAR_NONE;
            stop2_q     <= 1'b0;
            stop_bad_q  <= 1'b0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            ovr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= uart_rx_i;
            rx_s_q      <= sync1_q;
            armed_q     <= armed_d;
            div_q       <= div_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_acc_q   <= par_acc_d;
            par_err_q   <= par_err_d;
            parity_q    <= parity_d;
            stop2_q     <= stop2_d;
            stop_bad_q  <= stop_bad_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            ovr_err_q   <= ovr_err_d;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (DATA_BITS + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_q),
        .wdata_i ({par_err_q, shift_q}),
        .pop_i   (rx_if.rdy),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (rx_if.level)
    );

    assign rx_if.data          = fifo_rdata[DATA_BITS-1:0];
    assign rx_if.par_err       = fifo_rdata[DATA_BITS];
    assign rx_if.vld           = ~fifo_empty;
    assign uart_rx_frame_err_o = frame_err_q;
    assign uart_rx_ovr_err_o   = ovr_err_q;

endmodule
